fixed_point_divider: RTL and testbench

Sequential signed fixed-point divider, the inverse of the network's fixed-point multiplier: computes y = a / b in the same Q(DataWidth−FracBits).FracBits format used throughout the NN datapath. It is used for normalisation and scaling stages of the spike-detection network where a runtime divisor is needed. A valid/ready handshake on both sides lets a single shared instance be time-multiplexed across neurons.

---
 rtl/fixed_point_divider_pkg.sv | 31 +++
 rtl/fixed_point_divider_if.sv | 25 ++
 rtl/fixed_point_divider_div_step.sv | 28 ++
 rtl/fixed_point_divider.sv | 144 ++++++++++++++
 tb/tb_fixed_point_divider.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/fixed_point_divider_pkg.sv
// Shared types and widths for the sequential fixed-point divider.
// DATA_WIDTH and FRAC_BITS mirror the network datapath so the divider
// matches the fixed-point multiplier format.
package fixed_point_divider_pkg;

  localparam int DATA_WIDTH = 12;
  localparam int FRAC_BITS  = 8;
  // Dividend is |a| extended by FRAC_BITS zeros; one quotient bit per bit.
  localparam int QUOT_WIDTH = DATA_WIDTH + FRAC_BITS;
  localparam int CNT_WIDTH  = $clog2(QUOT_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_FINISH = 2'd2,
    ST_DONE   = 2'd3
  } div_state_e;

  // Magnitude of a two's complement value. The most negative input maps to
  // 2^(DATA_WIDTH-1), which is still representable as an unsigned value.
  function automatic logic [DATA_WIDTH-1:0] abs_mag(input logic [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] m;
    if (v[DATA_WIDTH-1]) begin
      m = ~v + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      m = v;
    end
    return m;
  endfunction

endpackage

// File: rtl/fixed_point_divider_if.sv
// Operand/result handshake bundle for the fixed-point divider.
// master = requester/consumer side, slave = divider side.
interface fixed_point_divider_if;

  logic                                        in_valid;
  logic                                        in_ready;
  logic [fixed_point_divider_pkg::DATA_WIDTH-1:0] a;
  logic [fixed_point_divider_pkg::DATA_WIDTH-1:0] b;
  logic                                        out_valid;
  logic                                        out_ready;
  logic [fixed_point_divider_pkg::DATA_WIDTH-1:0] y;
  logic                                        overflow;
  logic                                        div_by_zero;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, y, overflow, div_by_zero
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, y, overflow, div_by_zero
  );

endinterface

// File: rtl/fixed_point_divider_div_step.sv
// One restoring division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module fixed_point_divider_div_step
  import fixed_point_divider_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] i_rem,
  input  logic                  i_bit,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  output logic [DATA_WIDTH-1:0] o_rem,
  output logic                  o_q_bit
);

  logic [DATA_WIDTH:0] w_trial;

  // Trial subtraction; the remainder is always below the divisor, so the
  // low DATA_WIDTH bits of the difference are exact.
  always_comb begin
    w_trial = {i_rem, i_bit};
    if (w_trial >= {1'b0, i_divisor}) begin
      o_rem   = w_trial[DATA_WIDTH-1:0] - i_divisor;
      o_q_bit = 1'b1;
    end else begin
      o_rem   = w_trial[DATA_WIDTH-1:0];
      o_q_bit = 1'b0;
    end
  end

endmodule

// File: rtl/fixed_point_divider.sv
// Sequential signed fixed-point divider y = a / b (Q4.8 by default).
// Radix-2 restoring division on magnitudes, then sign and saturation.
module fixed_point_divider
  import fixed_point_divider_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  fixed_point_divider_if.slave  io_bus
);

  localparam logic [DATA_WIDTH-1:0] SAT_MAX    = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN    = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] DATA_ONE   = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [QUOT_WIDTH-1:0] QUOT_LIMIT =
    {{(QUOT_WIDTH-DATA_WIDTH){1'b0}}, 1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  CNT_LAST   = CNT_WIDTH'(QUOT_WIDTH - 1);

  div_state_e            r_state;
  logic                  r_sign_q;
  logic                  r_dbz;
  logic [DATA_WIDTH-1:0] r_divisor;
  logic [DATA_WIDTH-1:0] r_rem;
  // Holds the dividend bits still to be consumed (upper end) and the quotient
  // bits produced so far (lower end); after the last step it is the quotient.
  logic [QUOT_WIDTH-1:0] r_q;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [DATA_WIDTH-1:0] r_y;
  logic                  r_out_valid;
  logic                  r_overflow;
  logic                  r_div_by_zero;

  logic [DATA_WIDTH-1:0] w_rem_next;
  logic                  w_q_bit;
  logic [DATA_WIDTH-1:0] w_y_fin;
  logic                  w_ovf_fin;

  fixed_point_divider_div_step u_div_step (
    .i_rem     (r_rem),
    .i_bit     (r_q[QUOT_WIDTH-1]),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_next),
    .o_q_bit   (w_q_bit)
  );

  // Final result selection: sign restore with saturation, or the
  // divide-by-zero substitute chosen from the dividend's sign.
  always_comb begin
    w_y_fin   = {DATA_WIDTH{1'b0}};
    w_ovf_fin = 1'b0;
    if (r_dbz) begin
      if (r_q[QUOT_WIDTH-1 -: DATA_WIDTH] == {DATA_WIDTH{1'b0}}) begin
        w_y_fin = {DATA_WIDTH{1'b0}};
      end else if (r_sign_q) begin
        w_y_fin = SAT_MIN;
      end else begin
        w_y_fin = SAT_MAX;
      end
    end else if (!r_sign_q) begin
      if (r_q >= QUOT_LIMIT) begin
        w_y_fin   = SAT_MAX;
        w_ovf_fin = 1'b1;
      end else begin
        w_y_fin   = r_q[DATA_WIDTH-1:0];
      end
    end else begin
      if (r_q > QUOT_LIMIT) begin
        w_y_fin   = SAT_MIN;
        w_ovf_fin = 1'b1;
      end else begin
        w_y_fin   = ~r_q[DATA_WIDTH-1:0] + DATA_ONE;
      end
    end
  end

  // Control FSM with all datapath registers and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_sign_q      <= 1'b0;
      r_dbz         <= 1'b0;
      r_divisor     <= {DATA_WIDTH{1'b0}};
      r_rem         <= {DATA_WIDTH{1'b0}};
      r_q           <= {QUOT_WIDTH{1'b0}};
      r_cnt         <= {CNT_WIDTH{1'b0}};
      r_y           <= {DATA_WIDTH{1'b0}};
      r_out_valid   <= 1'b0;
      r_overflow    <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (io_bus.in_valid) begin
            r_sign_q  <= io_bus.a[DATA_WIDTH-1] ^ io_bus.b[DATA_WIDTH-1];
            r_q       <= {abs_mag(io_bus.a), {FRAC_BITS{1'b0}}};
            r_divisor <= abs_mag(io_bus.b);
            r_rem     <= {DATA_WIDTH{1'b0}};
            r_cnt     <= {CNT_WIDTH{1'b0}};
            if (io_bus.b == {DATA_WIDTH{1'b0}}) begin
              r_dbz   <= 1'b1;
              r_state <= ST_FINISH;
            end else begin
              r_dbz   <= 1'b0;
              r_state <= ST_DIVIDE;
            end
          end
        end
        ST_DIVIDE: begin
          r_rem <= w_rem_next;
          r_q   <= {r_q[QUOT_WIDTH-2:0], w_q_bit};
          if (r_cnt == CNT_LAST) begin
            r_state <= ST_FINISH;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_FINISH: begin
          r_y           <= w_y_fin;
          r_overflow    <= w_ovf_fin;
          r_div_by_zero <= r_dbz;
          r_out_valid   <= 1'b1;
          r_state       <= ST_DONE;
        end
        ST_DONE: begin
          if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign io_bus.in_ready    = (r_state == ST_IDLE);
  assign io_bus.out_valid   = r_out_valid;
  assign io_bus.y           = r_y;
  assign io_bus.overflow    = r_overflow;
  assign io_bus.div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_fixed_point_divider.sv
// Self-checking bench for fixed_point_divider: a vector table applied in a
// loop plus directed sequences for stall, early out_ready, operand toggling
// and reset during a division. Expected results go through a scoreboard queue.
module tb_fixed_point_divider;

  logic clk;
  logic rst_n;

  fixed_point_divider_if bus ();

  fixed_point_divider dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] y;
    logic        ovf;
    logic        dbz;
    int          lat;
  } vec_t;

  typedef struct {
    logic [11:0] y;
    logic        ovf;
    logic        dbz;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks;
  int   n_errors;

  localparam int NV = 16;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [11:0] ta, input logic [11:0] tbv, input exp_t e);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_before_issue", {31'd0, bus.in_ready}, 32'd1);
    bus.a        = ta;
    bus.b        = tbv;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    sb_q.push_back(e);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("out_valid_timeout", {31'd0, bus.out_valid}, 32'd1);
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_scoreboard: got result with no expectation queued", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_y"},   {20'd0, bus.y},           {20'd0, e.y});
      chk({tag, "_ovf"}, {31'd0, bus.overflow},    {31'd0, e.ovf});
      chk({tag, "_dbz"}, {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
    end
  endtask

  task automatic retire(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_retire_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_retire_in_ready"},  {31'd0, bus.in_ready},  32'd1);
  endtask

  function automatic exp_t mk(input logic [11:0] y, input logic ovf, input logic dbz);
    exp_t e;
    e.y   = y;
    e.ovf = ovf;
    e.dbz = dbz;
    return e;
  endfunction

  initial begin
    int lat;
    logic [11:0] held_y;

    n_checks = 0;
    n_errors = 0;

    //            a        b        y        ovf   dbz   lat
    vecs[0]  = '{12'd512,  12'd256, 12'd512,  1'b0, 1'b0, 21};
    vecs[1]  = '{12'd256,  12'd768, 12'd85,   1'b0, 1'b0, 21};
    vecs[2]  = '{12'hF00,  12'd768, 12'hFAB,  1'b0, 1'b0, 21};
    vecs[3]  = '{12'd2047, 12'd1,   12'h7FF,  1'b1, 1'b0, 21};
    vecs[4]  = '{12'h800,  12'd1,   12'h800,  1'b1, 1'b0, 21};
    vecs[5]  = '{12'h800,  12'h800, 12'd256,  1'b0, 1'b0, 21};
    vecs[6]  = '{12'd100,  12'd0,   12'h7FF,  1'b0, 1'b1, 1};
    vecs[7]  = '{12'd0,    12'd0,   12'h000,  1'b0, 1'b1, 1};
    vecs[8]  = '{12'hFFB,  12'd0,   12'h800,  1'b0, 1'b1, 1};
    vecs[9]  = '{12'd8,    12'd1,   12'h7FF,  1'b1, 1'b0, 21};
    vecs[10] = '{12'hFF8,  12'd1,   12'h800,  1'b0, 1'b0, 21};
    vecs[11] = '{12'd7,    12'd1,   12'd1792, 1'b0, 1'b0, 21};
    vecs[12] = '{12'd256,  12'hF00, 12'hF00,  1'b0, 1'b0, 21};
    vecs[13] = '{12'd1,    12'h7FF, 12'd0,    1'b0, 1'b0, 21};
    vecs[14] = '{12'hFFF,  12'h7FF, 12'd0,    1'b0, 1'b0, 21};
    vecs[15] = '{12'h7FF,  12'h7FF, 12'd256,  1'b0, 1'b0, 21};

    bus.in_valid  = 1'b0;
    bus.a         = 12'd0;
    bus.b         = 12'd0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, bus.out_valid},   32'd0);
    chk("reset_y",         {20'd0, bus.y},           32'd0);
    chk("reset_overflow",  {31'd0, bus.overflow},    32'd0);
    chk("reset_dbz",       {31'd0, bus.div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_in_ready",  {31'd0, bus.in_ready},    32'd1);

    // Vector table.
    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].a, vecs[i].b, mk(vecs[i].y, vecs[i].ovf, vecs[i].dbz));
      wait_out(lat);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      compare_out($sformatf("vec%0d", i));
      retire($sformatf("vec%0d", i));
    end

    // Stall: result and in_ready hold while out_ready stays low.
    issue(12'd512, 12'd256, mk(12'd512, 1'b0, 1'b0));
    wait_out(lat);
    held_y = bus.y;
    compare_out("stall");
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("stall_y_stable",   {20'd0, bus.y},         {20'd0, 12'd512});
      chk("stall_out_valid",  {31'd0, bus.out_valid}, 32'd1);
      chk("stall_in_ready",   {31'd0, bus.in_ready},  32'd0);
    end
    retire("stall");
    chk("stall_y_after_retire", {20'd0, bus.y}, {20'd0, held_y});

    // out_ready high before the result: visible for exactly one cycle.
    bus.out_ready = 1'b1;
    issue(12'd100, 12'd0, mk(12'h7FF, 1'b0, 1'b1));
    wait_out(lat);
    chk("early_ready_latency", lat, 1);
    compare_out("early_ready");
    @(posedge clk); #1;
    chk("early_ready_one_cycle", {31'd0, bus.out_valid}, 32'd0);
    chk("early_ready_in_ready",  {31'd0, bus.in_ready},  32'd1);
    bus.out_ready = 1'b0;

    // Operands changing mid-division must not affect the result.
    issue(12'd256, 12'd768, mk(12'd85, 1'b0, 1'b0));
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      bus.a = 12'($urandom);
      bus.b = 12'($urandom);
    end
    wait_out(lat);
    compare_out("toggle");
    retire("toggle");

    // Reset at cycle 10 of a division discards it.
    issue(12'd2047, 12'd3, mk(12'h000, 1'b0, 1'b0));
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", {31'd0, bus.out_valid},   32'd0);
    chk("midreset_y",         {20'd0, bus.y},           32'd0);
    chk("midreset_overflow",  {31'd0, bus.overflow},    32'd0);
    chk("midreset_dbz",       {31'd0, bus.div_by_zero}, 32'd0);
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midreset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    issue(12'd768, 12'd256, mk(12'd768, 1'b0, 1'b0));
    wait_out(lat);
    chk("post_reset_latency", lat, 21);
    compare_out("post_reset");
    retire("post_reset");

    chk("scoreboard_drained", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
